// File: rtl/pulse_stretch_enable.sv
// Stretches single-cycle enable strobes into STRETCH-cycle enables separated by at least GAP low cycles.
// Latency: slow_enable rises one cycle after an accepted strobe; further strobes queue in a pending counter.
// Backpressure: none; strobes beyond MAX_PEND queued events are dropped and flagged by sticky overflow.
module pulse_stretch_enable #(
  parameter int STRETCH  = 8,
  parameter int GAP      = 2,
  parameter int MAX_PEND = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fast_pulse,
  input  logic                          clear_ovf,
  output logic                          slow_enable,
  output logic                          busy,
  output logic [$clog2(MAX_PEND+1)-1:0] pending,
  output logic                          overflow
);

  localparam int PW      = $clog2(MAX_PEND + 1);
  localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PEND_FULL    = PW'(MAX_PEND);
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic            slow_enable_q, slow_enable_d;
  logic            busy_q, busy_d;

  logic            gap_last;
  logic            start;
  logic            drop;

  // Start decision shared by the FSM and the pending counter
  always_comb begin
    gap_last = (state_q == ST_GAP) && (cnt_q == '0);
    start    = ((state_q == ST_IDLE) || gap_last) &&
               ((pending_q != '0) || fast_pulse);
    drop     = fast_pulse && !start && (pending_q == PEND_FULL);
  end

  // State, counter and registered outputs; reset aborts any stretch and flushes queued events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pending_q     <= '0;
      overflow_q    <= 1'b0;
      slow_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      slow_enable_q <= slow_enable_d;
      busy_q        <= busy_d;
    end
  end

  // Next state; the phase counter reloads on every state entry and counts down to the final cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HIGH;
          cnt_d   = STRETCH_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          if (start) begin
            state_d = ST_HIGH;
            cnt_d   = STRETCH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops
  always_comb begin
    slow_enable_d = (state_d == ST_HIGH);
    busy_d        = (state_d != ST_IDLE);
  end

  // Pending queue: a start pulls one queued event (a coincident strobe refills it); a start with
  // nothing queued consumes the strobe directly; otherwise strobes queue until full, then drop
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      if ((pending_q != '0) && !fast_pulse) begin
        pending_d = pending_q - 1'b1;
      end
    end else if (fast_pulse && (pending_q != PEND_FULL)) begin
      pending_d = pending_q + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves the flag set
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  assign slow_enable = slow_enable_q;
  assign busy        = busy_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pulse_stretch_enable.sv
// Directed bench for pulse_stretch_enable at default parameters.
// Cycle n is the interval following edge n-1; outputs are sampled 1 time unit after each rising edge.
module tb_pulse_stretch_enable;

  logic       clk;
  logic       rst;
  logic       fast_pulse;
  logic       clear_ovf;
  logic       slow_enable;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int checks;
  int errors;

  pulse_stretch_enable #(.STRETCH(8), .GAP(2), .MAX_PEND(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fast_pulse (fast_pulse),
    .clear_ovf  (clear_ovf),
    .slow_enable(slow_enable),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fast_pulse = 1'b0;
    clear_ovf  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    fast_pulse = 1'b0;
    clear_ovf  = 1'b0;
    #3;
    checks++;
    if ({slow_enable, busy, pending, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got se=%b busy=%b pend=%0d ovf=%b, want all 0",
               slow_enable, busy, pending, overflow);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single strobe on the first edge after reset release
  task automatic test_single();
    logic exp_se, exp_busy;
    do_reset();
    fast_pulse = 1'b1;
    tick();
    fast_pulse = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_se   = (c >= 1 && c <= 8);
      exp_busy = (c <= 10);
      checks++;
      if (slow_enable !== exp_se || busy !== exp_busy || pending !== 3'd0) begin
        errors++;
        $display("FAIL single c%0d: got se=%b busy=%b pend=%0d, want se=%b busy=%b pend=0",
                 c, slow_enable, busy, pending, exp_se, exp_busy);
      end
      tick();
    end
  endtask

  // Strobes at edges 0,1,2
  task automatic test_back_to_back();
    logic exp_se;
    do_reset();
    for (int e = 0; e <= 31; e++) begin
      fast_pulse = (e <= 2);
      tick();
      // now in cycle e+1
      exp_se = ((e + 1) >= 1 && (e + 1) <= 8) || ((e + 1) >= 11 && (e + 1) <= 18) ||
               ((e + 1) >= 21 && (e + 1) <= 28);
      checks++;
      if (slow_enable !== exp_se) begin
        errors++;
        $display("FAIL b2b_se c%0d: got %b, want %b", e + 1, slow_enable, exp_se);
      end
      if (e == 1 || e == 2 || e == 10 || e == 20) begin
        checks++;
        if (pending !== ((e == 1) ? 3'd1 : (e == 2) ? 3'd2 : (e == 10) ? 3'd1 : 3'd0)) begin
          errors++;
          $display("FAIL b2b_pend after edge %0d: got %0d", e, pending);
        end
      end
    end
    fast_pulse = 1'b0;
  endtask

  // Strobes at edges 0..5 overflow the queue; clear at edge 10
  task automatic test_overflow();
    int highs;
    highs = 0;
    do_reset();
    for (int e = 0; e <= 59; e++) begin
      fast_pulse = (e <= 5);
      clear_ovf  = (e == 10);
      tick();
      if (slow_enable === 1'b1) highs++;
      if (e == 4) begin
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_fill: got pend=%0d ovf=%b, want pend=4 ovf=0", pending, overflow);
        end
      end
      if (e == 5 || e == 9) begin
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_set after edge %0d: got pend=%0d ovf=%b, want pend=4 ovf=1",
                   e, pending, overflow);
        end
      end
      if (e == 10) begin
        checks++;
        if (overflow !== 1'b0 || pending !== 3'd3) begin
          errors++;
          $display("FAIL ovf_clear: got ovf=%b pend=%0d, want ovf=0 pend=3", overflow, pending);
        end
      end
      if (e == 40) begin
        checks++;
        if (pending !== 3'd0 || slow_enable !== 1'b1) begin
          errors++;
          $display("FAIL ovf_last_start: got pend=%0d se=%b, want pend=0 se=1", pending, slow_enable);
        end
      end
    end
    fast_pulse = 1'b0;
    clear_ovf  = 1'b0;
    checks++;
    if (highs != 40 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_total: got %0d high cycles busy=%b, want 40 busy=0", highs, busy);
    end
  endtask

  // One queued event plus a strobe on the final GAP cycle
  task automatic test_gap_restart();
    do_reset();
    for (int e = 0; e <= 10; e++) begin
      fast_pulse = (e <= 1) || (e == 10);
      tick();
      if (e == 9) begin
        checks++;
        if (slow_enable !== 1'b0 || busy !== 1'b1 || pending !== 3'd1) begin
          errors++;
          $display("FAIL gap_last: got se=%b busy=%b pend=%0d, want se=0 busy=1 pend=1",
                   slow_enable, busy, pending);
        end
      end
    end
    fast_pulse = 1'b0;
    checks++;
    if (slow_enable !== 1'b1 || pending !== 3'd1) begin
      errors++;
      $display("FAIL gap_restart: got se=%b pend=%0d, want se=1 pend=1", slow_enable, pending);
    end
  endtask

  // Drop and clear in the same cycle: set wins
  task automatic test_drop_clear();
    do_reset();
    for (int e = 0; e <= 5; e++) begin
      fast_pulse = 1'b1;
      clear_ovf  = (e == 5);
      tick();
    end
    fast_pulse = 1'b0;
    clear_ovf  = 1'b0;
    checks++;
    if (overflow !== 1'b1 || pending !== 3'd4) begin
      errors++;
      $display("FAIL drop_clear: got ovf=%b pend=%0d, want ovf=1 pend=4", overflow, pending);
    end
  endtask

  // Reset in cycle 4 of HIGH with two queued events, then a fresh strobe
  task automatic test_mid_reset();
    do_reset();
    for (int e = 0; e <= 3; e++) begin
      fast_pulse = (e <= 2);
      tick();
    end
    fast_pulse = 1'b0;
    checks++;
    if (slow_enable !== 1'b1 || pending !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre: got se=%b pend=%0d, want se=1 pend=2", slow_enable, pending);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (slow_enable !== 1'b0 || pending !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got se=%b pend=%0d busy=%b, want 0 0 0", slow_enable, pending, busy);
    end
    #2;
    rst        = 1'b0;
    fast_pulse = 1'b1;
    tick();
    fast_pulse = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (slow_enable !== (c <= 8) || pending !== 3'd0) begin
        errors++;
        $display("FAIL mid_after c%0d: got se=%b pend=%0d, want se=%b pend=0",
                 c, slow_enable, pending, (c <= 8));
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_restart();
    test_drop_clear();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
